aes_enc_arbiter: RTL and testbench

AES_ENC_ARBITER -- requirements
Module: aes_enc_arbiter

---
 rtl/aes_enc_arbiter.sv | 145 ++++++++++++++
 tb/tb_aes_enc_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_arbiter.sv
// Two-channel round-robin front end for one shared AES-128 core, with per-channel CBC chaining.
// Optional WAIT watchdog is compiled in when the macro AES_ARB_TIMEOUT_EN is defined.

module aes_enc_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         vclk,
  input  logic         vrst,
  input  logic [1:0]   req,
  input  logic [255:0] data_i,
  input  logic [255:0] key_i,
  input  logic [1:0]   cbc_en,
  input  logic [1:0]   iv_ld,
  input  logic [255:0] iv_i,
  output logic [1:0]   ack,
  output logic [1:0]   rsp_valid,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic         core_ld,
  output logic [127:0] core_key,
  output logic [127:0] core_text,
  input  logic         core_done,
  input  logic [127:0] core_text_out
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t       r_state, w_next;
  logic         r_grant, r_last, r_cbc, r_err;
  logic [127:0] r_chain0, r_chain1;
  logic [127:0] r_core_key, r_core_text, r_rsp_data;
  logic         w_start, w_sel, w_sel_cbc, w_timeout, w_chain_upd;
  logic [127:0] w_sel_key, w_sel_data, w_sel_chain;

  assign w_start = (r_state == S_IDLE) && (req != 2'b00);

  // A lone requester always wins; on a tie the channel not served last goes first.
  always_comb begin
    w_sel = r_last;
    case (req)
      2'b01:   w_sel = 1'b0;
      2'b10:   w_sel = 1'b1;
      2'b11:   w_sel = ~r_last;
      default: w_sel = r_last;
    endcase
  end

  assign w_sel_key   = w_sel ? key_i[255:128]  : key_i[127:0];
  assign w_sel_data  = w_sel ? data_i[255:128] : data_i[127:0];
  assign w_sel_chain = w_sel ? r_chain1        : r_chain0;
  assign w_sel_cbc   = w_sel ? cbc_en[1]       : cbc_en[0];

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge vclk) begin
    if (vrst)                   r_cnt <= '0;
    else if (r_state != S_WAIT) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign rsp_err   = (r_state == S_DONE) && r_err;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_timeout        = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_LOAD;
      S_LOAD:  w_next = S_WAIT;
      S_WAIT:  if (core_done || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: every clocked block uses <= so all registers see pre-edge values, independent of block order.
  always_ff @(posedge vclk) begin
    if (vrst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Core operands are captured on entry to LOAD so they are already valid while core_ld is high.
  always_ff @(posedge vclk) begin
    if (vrst) begin
      r_grant     <= 1'b0;
      r_last      <= 1'b1;
      r_cbc       <= 1'b0;
      r_err       <= 1'b0;
      r_core_key  <= '0;
      r_core_text <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_start) begin
        r_grant     <= w_sel;
        r_last      <= w_sel;
        r_cbc       <= w_sel_cbc;
        r_err       <= 1'b0;
        r_core_key  <= w_sel_key;
        r_core_text <= w_sel_cbc ? (w_sel_data ^ w_sel_chain) : w_sel_data;
      end
      if (r_state == S_WAIT) begin
        if (core_done) begin
          r_rsp_data <= core_text_out;
          r_err      <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_data <= '0;
          r_err      <= 1'b1;
        end
      end
    end
  end

  // Chain update happens in the DONE cycle; a simultaneous IV load takes priority.
  assign w_chain_upd = (r_state == S_DONE) && r_cbc && !r_err;

  always_ff @(posedge vclk) begin
    if (vrst) begin
      r_chain0 <= '0;
      r_chain1 <= '0;
    end else begin
      if (iv_ld[0])                     r_chain0 <= iv_i[127:0];
      else if (w_chain_upd && !r_grant) r_chain0 <= r_rsp_data;
      if (iv_ld[1])                     r_chain1 <= iv_i[255:128];
      else if (w_chain_upd && r_grant)  r_chain1 <= r_rsp_data;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign core_ld   = (r_state == S_LOAD);
  assign ack       = core_ld ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (r_state == S_DONE) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = r_rsp_data;
  assign core_key  = r_core_key;
  assign core_text = r_core_text;

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Self-checking bench for aes_enc_arbiter: a behavioural AES-128 core model answers core_ld,
// and a job-level reference model (chain values, last grant) predicts every response.

module tb_aes_enc_arbiter;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         vclk = 1'b0;
  logic         vrst;
  logic [1:0]   req, cbc_en, iv_ld;
  logic [255:0] data_i, key_i, iv_i;
  logic [1:0]   ack, rsp_valid;
  logic [127:0] rsp_data, core_key, core_text;
  logic         rsp_err, busy, core_ld;
  logic         core_done = 1'b0;
  logic [127:0] core_text_out = '0;

  aes_enc_arbiter #(.TIMEOUT(8)) dut (
    .vclk(vclk), .vrst(vrst), .req(req), .data_i(data_i), .key_i(key_i),
    .cbc_en(cbc_en), .iv_ld(iv_ld), .iv_i(iv_i), .ack(ack), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .core_ld(core_ld),
    .core_key(core_key), .core_text(core_text), .core_done(core_done),
    .core_text_out(core_text_out)
  );

  always #5 vclk = ~vclk;

  int cyc = 0;
  always @(posedge vclk) cyc++;

  int errors = 0;
  int checks = 0;

  // ---------------- AES-128 reference (FIPS-197, computed from GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rk [16];
    logic [7:0] rcon = 8'h01;
    logic [7:0] a0, a1, a2, a3, k0, k1, k2, k3;
    logic [127:0] ct;
    for (int i = 0; i < 16; i++) begin
      rk[i] = key[127 - 8*i -: 8];
      s[i]  = pt[127 - 8*i -: 8] ^ rk[i];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      k0 = sbox(rk[13]); k1 = sbox(rk[14]); k2 = sbox(rk[15]); k3 = sbox(rk[12]);
      rk[0] = rk[0] ^ k0 ^ rcon; rk[1] = rk[1] ^ k1; rk[2] = rk[2] ^ k2; rk[3] = rk[3] ^ k3;
      for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
      rcon = xt(rcon);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4*c] = sbox(s[r + 4*((c + r) % 4)]);
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
    end
    for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
    return ct;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- core model: answers each core_ld after 1..4 cycles ----------------
  bit           core_en = 1'b1;
  bit           inject  = 1'b0;
  bit           core_pend = 1'b0;
  int           core_cnt;
  int           done_cyc = 0;
  logic [127:0] core_res;

  always @(posedge vclk) begin
    #1;
    core_done = 1'b0;
    if (vrst) begin
      core_pend = 1'b0;
    end else if (core_pend) begin
      if (core_cnt == 0) begin
        core_done     = 1'b1;
        core_text_out = core_res;
        core_pend     = 1'b0;
        done_cyc      = cyc;
      end else begin
        core_cnt--;
      end
    end else if (core_en && core_ld) begin
      core_res  = aes128(core_key, core_text);
      core_cnt  = $urandom_range(0, 3);
      core_pend = 1'b1;
    end
    if (inject) begin
      core_done     = 1'b1;
      core_text_out = 128'hdeadbeef_00c0ffee_0badf00d_12345678;
    end
  end

  // ---------------- job-level reference model ----------------
  logic [127:0] m_chain [2];
  bit           m_last;
  logic [127:0] m_rsp;
  logic [127:0] j_key [2];
  logic [127:0] j_data [2];
  bit           j_cbc [2];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge vclk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      tick();
    end
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid != 2'b00) break;
      tick();
    end
  endtask

  task automatic apply_inputs();
    data_i = {j_data[1], j_data[0]};
    key_i  = {j_key[1], j_key[0]};
    cbc_en = {j_cbc[1], j_cbc[0]};
  endtask

  task automatic start(input logic [1:0] mask);
    wait_idle();
    check("rsp_hold", rsp_data, m_rsp);
    apply_inputs();
    req = mask;
  endtask

  // mode: 0 drop granted req at ack, 1 keep both reqs, 2 drop all reqs at ack
  task automatic serve_one(input int mode, input bit do_iv, input logic [127:0] iv_val,
                           output logic [127:0] obs);
    bit           g;
    logic [1:0]   oh;
    logic [127:0] txt, exp;
    g   = (req == 2'b11) ? ~m_last : req[1];
    oh  = g ? 2'b10 : 2'b01;
    txt = j_cbc[g] ? (j_data[g] ^ m_chain[g]) : j_data[g];
    exp = aes128(j_key[g], txt);
    wait_idle();
    tick();
    check("ack", ack, oh);
    check("core_ld", core_ld, 1'b1);
    check("core_key", core_key, j_key[g]);
    check("core_text", core_text, txt);
    if (mode == 0)      req[g] = 1'b0;
    else if (mode == 2) req = 2'b00;
    m_last = g;
    wait_rsp();
    check("rsp_valid", rsp_valid, oh);
    check("rsp_data", rsp_data, exp);
    check("rsp_err", rsp_err, 1'b0);
    check("done_to_rsp", 128'(cyc - done_cyc), 128'd1);
    obs = rsp_data;
    if (do_iv) begin
      iv_ld[g] = 1'b1;
      if (g) iv_i[255:128] = iv_val;
      else   iv_i[127:0]   = iv_val;
      m_chain[g] = iv_val;
    end else if (j_cbc[g]) begin
      m_chain[g] = exp;
    end
    m_rsp = exp;
    tick();
    iv_ld = 2'b00;
  endtask

  logic [127:0] obs, x;
  logic [1:0]   mask;
  int           c0;

  initial begin
    vrst = 1'b1; req = 2'b00; data_i = '0; key_i = '0; cbc_en = 2'b00;
    iv_ld = 2'b00; iv_i = '0;
    m_chain[0] = '0; m_chain[1] = '0; m_last = 1'b1; m_rsp = '0;
    for (int c = 0; c < 2; c++) begin j_key[c] = '0; j_data[c] = '0; j_cbc[c] = 1'b0; end
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_ack", ack, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_core_ld", core_ld, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_core_key", core_key, '0);
    check("rst_core_text", core_text, '0);
    vrst = 1'b0;
    tick();

    // Both channels requesting continuously: ch0, ch1, ch0, ch1.
    for (int c = 0; c < 2; c++) begin j_key[c] = rnd128(); j_data[c] = rnd128(); j_cbc[c] = 1'b0; end
    start(2'b11);
    for (int k = 0; k < 4; k++) serve_one((k == 3) ? 2 : 1, 1'b0, '0, obs);

    // FIPS-197 vector on ch0.
    j_key[0] = FIPS_KEY; j_data[0] = FIPS_PT; j_cbc[0] = 1'b0;
    start(2'b01);
    serve_one(0, 1'b0, '0, obs);
    check("fips_ch0", obs, FIPS_CT);

    // ch1 CBC from a zero IV: two identical blocks, then expose chain1 through a zero block.
    wait_idle();
    iv_ld = 2'b10; iv_i[255:128] = '0; tick(); iv_ld = 2'b00; m_chain[1] = '0;
    j_key[1] = FIPS_KEY; j_data[1] = FIPS_PT; j_cbc[1] = 1'b1;
    start(2'b10);
    serve_one(0, 1'b0, '0, obs);
    check("cbc_blk1", obs, FIPS_CT);
    start(2'b10);
    serve_one(0, 1'b0, '0, obs);
    check("cbc_blk2", obs, aes128(FIPS_KEY, FIPS_PT ^ FIPS_CT));
    j_data[1] = '0;
    start(2'b10);
    serve_one(0, 1'b0, '0, obs);

    // IV load in the DONE cycle of ch0 beats the chain update.
    j_key[0] = rnd128(); j_data[0] = rnd128(); j_cbc[0] = 1'b1; x = rnd128();
    start(2'b01);
    serve_one(0, 1'b1, x, obs);
    j_data[0] = '0;
    start(2'b01);
    serve_one(0, 1'b0, '0, obs);

    // Randomized jobs.
    for (int s = 0; s < 12; s++) begin
      mask = 2'($urandom_range(1, 3));
      for (int c = 0; c < 2; c++) begin
        j_key[c] = rnd128(); j_data[c] = rnd128(); j_cbc[c] = 1'($urandom_range(0, 1));
      end
      start(mask);
      while (req != 2'b00) serve_one(0, ($urandom_range(0, 3) == 0), rnd128(), obs);
    end

    // Reset during WAIT, then a stray core_done.
    core_en = 1'b0;
    j_key[0] = rnd128(); j_data[0] = rnd128(); j_cbc[0] = 1'b0;
    start(2'b01);
    tick();
    check("abort_ack", ack, 2'b01);
    req = 2'b00;
    tick(); tick();
    check("abort_busy_wait", busy, 1'b1);
    vrst = 1'b1; tick(); vrst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_rsp_valid", rsp_valid, 2'b00);
    check("abort_rsp_data", rsp_data, '0);
    check("abort_core_key", core_key, '0);
    check("abort_core_text", core_text, '0);
    m_chain[0] = '0; m_chain[1] = '0; m_last = 1'b1; m_rsp = '0;
    inject = 1'b1; tick(); inject = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("late_done_valid", rsp_valid, 2'b00);
      check("late_done_busy", busy, 1'b0);
      tick();
    end
    core_en = 1'b1;

    // After reset the tie goes to ch0 again, and chains start from zero.
    for (int c = 0; c < 2; c++) begin j_key[c] = rnd128(); j_data[c] = rnd128(); j_cbc[c] = 1'b1; end
    start(2'b11);
    serve_one(0, 1'b0, '0, obs);
    serve_one(0, 1'b0, '0, obs);

`ifdef AES_ARB_TIMEOUT_EN
    // Watchdog: core never answers, error response exactly TIMEOUT cycles after WAIT entry.
    x = rnd128();
    wait_idle();
    iv_ld = 2'b01; iv_i[127:0] = x; tick(); iv_ld = 2'b00; m_chain[0] = x;
    core_en = 1'b0;
    j_key[0] = rnd128(); j_data[0] = rnd128(); j_cbc[0] = 1'b1;
    start(2'b01);
    tick();
    c0 = cyc;
    check("to_ack", ack, 2'b01);
    req = 2'b00; m_last = 1'b0;
    wait_rsp();
    check("to_latency", 128'(cyc - c0), 128'd9);
    check("to_rsp_valid", rsp_valid, 2'b01);
    check("to_rsp_err", rsp_err, 1'b1);
    check("to_rsp_data", rsp_data, '0);
    m_rsp = '0;
    tick();
    core_en = 1'b1;
    j_data[0] = '0;
    start(2'b01);
    serve_one(0, 1'b0, '0, obs);
`endif

    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
